// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_pkg: 4x4 keypad layout, key-to-row/column map, emulator states    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BOUNCE_PRESS   = 2'd1,
    HOLD           = 2'd2,
    BOUNCE_RELEASE = 2'd3
  } emu_state_t;

  // Layout: row0 1 2 3 A | row1 4 5 6 B | row2 7 8 9 C | row3 E 0 F D
  function automatic logic [3:0] key2rc(input logic [3:0] code);
    logic [3:0] rc;
    unique case (code)
      4'h1: rc = {2'd0, 2'd0};
      4'h2: rc = {2'd0, 2'd1};
      4'h3: rc = {2'd0, 2'd2};
      4'hA: rc = {2'd0, 2'd3};
      4'h4: rc = {2'd1, 2'd0};
      4'h5: rc = {2'd1, 2'd1};
      4'h6: rc = {2'd1, 2'd2};
      4'hB: rc = {2'd1, 2'd3};
      4'h7: rc = {2'd2, 2'd0};
      4'h8: rc = {2'd2, 2'd1};
      4'h9: rc = {2'd2, 2'd2};
      4'hC: rc = {2'd2, 2'd3};
      4'hE: rc = {2'd3, 2'd0};
      4'h0: rc = {2'd3, 2'd1};
      4'hF: rc = {2'd3, 2'd2};
      4'hD: rc = {2'd3, 2'd3};
    endcase
    return rc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4) with step enable              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (en) begin
      q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | keypad_emulator: passive 4x4 keypad matrix with press/release bounce     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int         BOUNCE_CYCLES = 4800,
  parameter int         HOLD_W        = 24,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        rowScan,
  output logic [3:0]        colOut,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              key_ready,
  output logic              pressed,
  output logic              done
);

  localparam int BNC_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int CNT_W = (HOLD_W > BNC_W) ? HOLD_W : BNC_W;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] BNC_LOAD =
    (BOUNCE_CYCLES > 0) ? CNT_W'(BOUNCE_CYCLES - 1) : '0;

  emu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hold_len;
  logic [CNT_W-1:0] hold_ext;
  logic [CNT_W-1:0] hold_load;
  logic [1:0]       key_row;
  logic [1:0]       key_col;
  logic [7:0]       lfsr_q;
  logic             lfsr_en;
  logic             contact;
  logic [3:0]       col_next;

  // Counter holds "cycles remaining minus one", so a zero hold becomes one cycle
  assign hold_ext  = CNT_W'(hold_cycles);
  assign hold_load = (hold_cycles == '0) ? '0 : hold_ext - CNT_ONE;
  assign lfsr_en   = (state == BOUNCE_PRESS) || (state == BOUNCE_RELEASE);

  lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (lfsr_en),
    .q     (lfsr_q)
  );

  always_comb begin
    contact  = 1'b0;
    col_next = 4'hF;
    unique case (state)
      BOUNCE_PRESS, BOUNCE_RELEASE: contact = lfsr_q[0];
      HOLD:                         contact = 1'b1;
      default:                      contact = 1'b0;
    endcase
    if (contact && !rowScan[key_row]) begin
      col_next[key_col] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_len  <= '0;
      key_row   <= 2'd0;
      key_col   <= 2'd0;
      key_ready <= 1'b1;
      pressed   <= 1'b0;
      done      <= 1'b0;
      colOut    <= 4'hF;
    end else begin
      done   <= 1'b0;
      colOut <= col_next;
      case (state)
        IDLE: begin
          if (key_valid && key_ready) begin
            {key_row, key_col} <= key2rc(key_code);
            hold_len  <= hold_load;
            key_ready <= 1'b0;
            pressed   <= 1'b1;
            if (BOUNCE_CYCLES > 0) begin
              state <= BOUNCE_PRESS;
              cnt   <= BNC_LOAD;
            end else begin
              state <= HOLD;
              cnt   <= hold_load;
            end
          end
        end
        BOUNCE_PRESS: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= hold_len;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (BOUNCE_CYCLES > 0) begin
            state <= BOUNCE_RELEASE;
            cnt   <= BNC_LOAD;
          end else begin
            state     <= IDLE;
            done      <= 1'b1;
            pressed   <= 1'b0;
            key_ready <= 1'b1;
          end
        end
        BOUNCE_RELEASE: begin
          if (cnt == '0) begin
            state     <= IDLE;
            done      <= 1'b1;
            pressed   <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_keypad_emulator: scoreboard bench, bounce-free and 8-cycle-bounce DUTs|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_keypad_emulator;

  localparam logic [6:0] IDLE_EXP = {4'hF, 1'b0, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row0, row1, col0, col1, code0, code1;
  logic        v0, v1, rdy0, rdy1, pr0, pr1, dn0, dn1;
  logic [23:0] hold0, hold1;

  logic [6:0]  e0[$], e1[$];
  string       n0[$], n1[$];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  keypad_emulator #(.BOUNCE_CYCLES(0), .HOLD_W(24), .LFSR_SEED(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .rowScan(row0), .colOut(col0), .key_valid(v0),
    .key_code(code0), .hold_cycles(hold0), .key_ready(rdy0), .pressed(pr0), .done(dn0)
  );

  keypad_emulator #(.BOUNCE_CYCLES(8), .HOLD_W(24), .LFSR_SEED(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .rowScan(row1), .colOut(col1), .key_valid(v1),
    .key_code(code1), .hold_cycles(hold1), .key_ready(rdy1), .pressed(pr1), .done(dn1)
  );

  task automatic compare(input int sel, input string nm, input logic [6:0] exp, input logic [6:0] got);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got col=%b pressed=%b ready=%b done=%b, want col=%b pressed=%b ready=%b done=%b",
               nm, sel, got[6:3], got[2], got[1], got[0], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Expected outputs after the next clock edge; the other DUT is expected idle
  task automatic step(input int sel, input string nm, input logic [3:0] col,
                      input logic p, input logic r, input logic d);
    @(posedge clk);
    #1;
    if (sel == 0) begin
      e0.push_back({col, p, r, d}); n0.push_back(nm);
      e1.push_back(IDLE_EXP);       n1.push_back("idle");
    end else begin
      e1.push_back({col, p, r, d}); n1.push_back(nm);
      e0.push_back(IDLE_EXP);       n0.push_back("idle");
    end
  endtask

  always @(negedge clk) begin
    if (e0.size() > 0) compare(0, n0.pop_front(), e0.pop_front(), {col0, pr0, rdy0, dn0});
    if (e1.size() > 0) compare(1, n1.pop_front(), e1.pop_front(), {col1, pr1, rdy1, dn1});
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat [4];
    logic       press_b [8];
    logic       rel_b [8];
    pat     = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    press_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rel_b   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b0;
    row0 = 4'hF; row1 = 4'hF; v0 = 1'b0; v1 = 1'b0;
    code0 = 4'h0; code1 = 4'h0; hold0 = '0; hold1 = '0;
    step(0, "reset", 4'hF, 1'b0, 1'b1, 1'b0);
    step(0, "reset", 4'hF, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    step(0, "idle_after_reset", 4'hF, 1'b0, 1'b1, 1'b0);

    // Key '5', hold 10, no bounce; key_code changes right after acceptance
    v0 = 1'b1; code0 = 4'h5; hold0 = 24'd10; row0 = 4'b1101;
    step(0, "k5_accept", 4'hF, 1'b1, 1'b0, 1'b0);
    v0 = 1'b0; code0 = 4'hA;
    for (int k = 1; k <= 9; k++) step(0, "k5_hold", 4'b1101, 1'b1, 1'b0, 1'b0);
    step(0, "k5_done", 4'b1101, 1'b0, 1'b1, 1'b1);
    step(0, "k5_after", 4'hF, 1'b0, 1'b1, 1'b0);

    // hold_cycles = 0 behaves as one cycle
    v0 = 1'b1; code0 = 4'h1; hold0 = 24'd0; row0 = 4'b1110;
    step(0, "h0_accept", 4'hF, 1'b1, 1'b0, 1'b0);
    v0 = 1'b0;
    step(0, "h0_done", 4'b1110, 1'b0, 1'b1, 1'b1);
    step(0, "h0_after", 4'hF, 1'b0, 1'b1, 1'b0);

    // Key 'D' with the scanner cycling rows every cycle
    v0 = 1'b1; code0 = 4'hD; hold0 = 24'd20; row0 = pat[0];
    step(0, "kd_accept", 4'hF, 1'b1, 1'b0, 1'b0);
    v0 = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      row0 = pat[k % 4];
      step(0, "kd_scan", (k % 4 == 3) ? 4'b0111 : 4'hF,
           (k < 20), (k == 20), (k == 20));
    end
    row0 = pat[1];
    step(0, "kd_after", 4'hF, 1'b0, 1'b1, 1'b0);

    // key_valid held high: second key accepted only after done
    v0 = 1'b1; code0 = 4'h2; hold0 = 24'd3; row0 = 4'b1100;
    step(0, "hv_accept1", 4'hF, 1'b1, 1'b0, 1'b0);
    code0 = 4'h6;
    step(0, "hv_busy", 4'b1101, 1'b1, 1'b0, 1'b0);
    step(0, "hv_busy", 4'b1101, 1'b1, 1'b0, 1'b0);
    step(0, "hv_done1", 4'b1101, 1'b0, 1'b1, 1'b1);
    step(0, "hv_accept2", 4'hF, 1'b1, 1'b0, 1'b0);
    v0 = 1'b0;
    step(0, "hv_hold2", 4'b1011, 1'b1, 1'b0, 1'b0);
    step(0, "hv_hold2", 4'b1011, 1'b1, 1'b0, 1'b0);
    step(0, "hv_done2", 4'b1011, 1'b0, 1'b1, 1'b1);
    step(0, "hv_after", 4'hF, 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-HOLD between clock edges
    v0 = 1'b1; code0 = 4'h5; hold0 = 24'd50; row0 = 4'b1101;
    step(0, "rst_accept", 4'hF, 1'b1, 1'b0, 1'b0);
    v0 = 1'b0;
    step(0, "rst_hold", 4'b1101, 1'b1, 1'b0, 1'b0);
    step(0, "rst_hold", 4'b1101, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 compare(0, "rst_async", IDLE_EXP, {col0, pr0, rdy0, dn0});
    step(0, "rst_mid", 4'hF, 1'b0, 1'b1, 1'b0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step(0, "rst_no_done", 4'hF, 1'b0, 1'b1, 1'b0);

    // Key '0' with 8 cycles of bounce on press and release, LFSR from seed A5
    v1 = 1'b1; code1 = 4'h0; hold1 = 24'd5; row1 = 4'b0111;
    step(1, "b_accept", 4'hF, 1'b1, 1'b0, 1'b0);
    v1 = 1'b0;
    for (int k = 0; k < 8; k++) step(1, "b_press", press_b[k] ? 4'b1101 : 4'hF, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) step(1, "b_hold", 4'b1101, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step(1, "b_release", rel_b[k] ? 4'b1101 : 4'hF, 1'b1, 1'b0, 1'b0);
    step(1, "b_done", rel_b[7] ? 4'b1101 : 4'hF, 1'b0, 1'b1, 1'b1);
    step(1, "b_after", 4'hF, 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    #1;
    vectors++;
    if (e0.size() != 0 || e1.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", e0.size(), e1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
